// File: rtl/captura_operandos.sv
// Keypad front end for the divider: scans a 4x4 matrix, debounces presses and
// assembles a dividend/divisor pair, refusing to present a zero divisor.
module captura_operandos #(
  parameter int m           = 4,
  parameter int SCAN_CYCLES = 50000,
  parameter int DEBOUNCE    = 200000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   filas,
  output logic [3:0]   columnas,
  output logic [m-1:0] dividendo,
  output logic [m-1:0] divisor,
  output logic         listo,
  output logic         error_div0,
  output logic         tecla_evento
);

  localparam int CNT_MAX = (DEBOUNCE > SCAN_CYCLES) ? DEBOUNCE : SCAN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0]  DEB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [m+3:0]   MAXV      = {4'b0000, {m{1'b1}}};
  localparam logic [m+3:0]   DIEZ      = (m+4)'(10);

  localparam logic [3:0] K_STAR  = 4'd10;
  localparam logic [3:0] K_HASH  = 4'd11;
  localparam logic [3:0] K_LETRA = 4'd12;

  typedef enum logic [1:0] {BARRIDO, REBOTE_P, ESPERA_SOLTAR} scan_e;
  typedef enum logic [1:0] {ESPERA_A, ESPERA_B, LISTO} entrada_e;

  function automatic logic [3:0] decodifica(input logic [1:0] fila, input logic [1:0] col);
    case ({fila, col})
      4'h0: decodifica = 4'd1;
      4'h1: decodifica = 4'd2;
      4'h2: decodifica = 4'd3;
      4'h4: decodifica = 4'd4;
      4'h5: decodifica = 4'd5;
      4'h6: decodifica = 4'd6;
      4'h8: decodifica = 4'd7;
      4'h9: decodifica = 4'd8;
      4'hA: decodifica = 4'd9;
      4'hC: decodifica = K_STAR;
      4'hD: decodifica = 4'd0;
      4'hE: decodifica = K_HASH;
      default: decodifica = K_LETRA;
    endcase
  endfunction

  // Lowest-index low row wins when several keys share a column.
  function automatic logic [1:0] fila_baja(input logic [3:0] f);
    if (!f[0])      fila_baja = 2'd0;
    else if (!f[1]) fila_baja = 2'd1;
    else if (!f[2]) fila_baja = 2'd2;
    else            fila_baja = 2'd3;
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] c);
    case (c)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      default: col_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [m+3:0] acumula(input logic [m-1:0] v, input logic [3:0] d);
    acumula = {4'b0000, v} * DIEZ + {{m{1'b0}}, d};
  endfunction

  logic [3:0]    filas_s1_q, filas_s2_q;
  scan_e         scan_q, scan_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    columnas_q, columnas_d;
  logic [1:0]    fila_q, fila_d;
  logic [3:0]    codigo_q, codigo_d;
  logic          tecla_evento_q, tecla_evento_d;
  entrada_e      estado_q, estado_d;
  logic [m-1:0]  dividendo_q, dividendo_d;
  logic [m-1:0]  divisor_q, divisor_d;
  logic          listo_q, listo_d;
  logic          error_q, error_d;

  logic [3:0]    col_sig;
  logic [m+3:0]  cand_a, cand_b, digito_ext;
  logic          es_digito;

  assign col_sig = {columnas_q[2:0], columnas_q[3]};

  always_comb begin
    scan_d         = scan_q;
    cnt_d          = cnt_q;
    columnas_d     = columnas_q;
    fila_d         = fila_q;
    codigo_d       = codigo_q;
    tecla_evento_d = 1'b0;
    case (scan_q)
      BARRIDO: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (filas_s2_q != 4'hF) begin
            fila_d = fila_baja(filas_s2_q);
            scan_d = REBOTE_P;
          end else begin
            columnas_d = col_sig;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REBOTE_P: begin
        if (!filas_s2_q[fila_q]) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d          = '0;
            tecla_evento_d = 1'b1;
            codigo_d       = decodifica(fila_q, col_idx(columnas_q));
            scan_d         = ESPERA_SOLTAR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d      = '0;
          columnas_d = col_sig;
          scan_d     = BARRIDO;
        end
      end
      ESPERA_SOLTAR: begin
        if (filas_s2_q == 4'hF) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d      = '0;
            columnas_d = col_sig;
            scan_d     = BARRIDO;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        scan_d     = BARRIDO;
        cnt_d      = '0;
        columnas_d = 4'b1110;
      end
    endcase
  end

  assign es_digito  = (codigo_q <= 4'd9);
  assign cand_a     = acumula(dividendo_q, codigo_q);
  assign cand_b     = acumula(divisor_q, codigo_q);
  assign digito_ext = {{m{1'b0}}, codigo_q};

  // The key code registered with the pulse is consumed on the edge that ends the pulse.
  always_comb begin
    estado_d    = estado_q;
    dividendo_d = dividendo_q;
    divisor_d   = divisor_q;
    listo_d     = listo_q;
    error_d     = error_q;
    if (tecla_evento_q && codigo_q != K_LETRA) begin
      case (estado_q)
        ESPERA_A: begin
          if (es_digito) begin
            if (cand_a <= MAXV) dividendo_d = cand_a[m-1:0];
          end else if (codigo_q == K_HASH) begin
            divisor_d = '0;
            estado_d  = ESPERA_B;
          end else begin
            dividendo_d = '0;
          end
        end
        ESPERA_B: begin
          error_d = 1'b0;
          if (es_digito) begin
            if (cand_b <= MAXV) divisor_d = cand_b[m-1:0];
          end else if (codigo_q == K_HASH) begin
            if (divisor_q != '0) begin
              listo_d  = 1'b1;
              estado_d = LISTO;
            end else begin
              error_d = 1'b1;
            end
          end else begin
            dividendo_d = '0;
            divisor_d   = '0;
            estado_d    = ESPERA_A;
          end
        end
        LISTO: begin
          if (es_digito) begin
            dividendo_d = digito_ext[m-1:0];
            divisor_d   = '0;
            listo_d     = 1'b0;
            estado_d    = ESPERA_A;
          end else if (codigo_q == K_STAR) begin
            dividendo_d = '0;
            divisor_d   = '0;
            listo_d     = 1'b0;
            estado_d    = ESPERA_A;
          end
        end
        default: begin
          estado_d = ESPERA_A;
          listo_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filas_s1_q     <= 4'hF;
      filas_s2_q     <= 4'hF;
      scan_q         <= BARRIDO;
      cnt_q          <= '0;
      columnas_q     <= 4'b1110;
      fila_q         <= 2'd0;
      codigo_q       <= 4'd0;
      tecla_evento_q <= 1'b0;
      estado_q       <= ESPERA_A;
      dividendo_q    <= '0;
      divisor_q      <= '0;
      listo_q        <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      filas_s1_q     <= filas;
      filas_s2_q     <= filas_s1_q;
      scan_q         <= scan_d;
      cnt_q          <= cnt_d;
      columnas_q     <= columnas_d;
      fila_q         <= fila_d;
      codigo_q       <= codigo_d;
      tecla_evento_q <= tecla_evento_d;
      estado_q       <= estado_d;
      dividendo_q    <= dividendo_d;
      divisor_q      <= divisor_d;
      listo_q        <= listo_d;
      error_q        <= error_d;
    end
  end

  assign columnas     = columnas_q;
  assign dividendo    = dividendo_q;
  assign divisor      = divisor_q;
  assign listo        = listo_q;
  assign error_div0   = error_q;
  assign tecla_evento = tecla_evento_q;

endmodule
